// File: rtl/usr_btn_events_pkg.sv
// Shared state type and default timing constants for the user-button event block.
package usr_btn_events_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } btn_state_e;

  // 10 ms debounce and 1 s long-press threshold at 48 MHz
  localparam int unsigned DEBOUNCE_10MS_48M = 32'd480000;
  localparam int unsigned LONG_1S_48M       = 32'd48000000;

endpackage

// File: rtl/btn_sync_debounce.sv
// Two-flop synchroniser plus counter debouncer for the raw button pad.
// level_o is polarity-normalised: 1 means pressed.
module btn_sync_debounce
  import usr_btn_events_pkg::*;
#(
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_48M
) (
  input  logic clk48,
  input  logic rst_n,
  input  logic pad_i,
  output logic level_o
);

  localparam int unsigned DB_W         = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic        RELEASED_PAD = ACTIVE_LOW;

  logic            sync1_q;
  logic            sync2_q;
  logic            pressed;
  logic            level_q;
  logic            level_d;
  logic [DB_W-1:0] cnt_db_q;
  logic [DB_W-1:0] cnt_db_d;

  assign pressed = sync2_q ^ ACTIVE_LOW;

  // Any cycle where the synced level agrees with the accepted level restarts the count.
  always_comb begin
    level_d  = level_q;
    cnt_db_d = '0;
    if (pressed != level_q) begin
      if (cnt_db_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_db_d = cnt_db_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= RELEASED_PAD;
      sync2_q  <= RELEASED_PAD;
      level_q  <= 1'b0;
      cnt_db_q <= '0;
    end else begin
      sync1_q  <= pad_i;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      cnt_db_q <= cnt_db_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/usr_btn_events.sv
// User push-button conditioner: debounced level, press/release pulses and
// short/long press classification, all outputs registered.
module usr_btn_events
  import usr_btn_events_pkg::*;
#(
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_48M,
  parameter int unsigned LONG_CYCLES     = LONG_1S_48M
) (
  input  logic clk48,
  input  logic rst_n,
  input  logic usr_btn,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic long_hold
);

  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

  logic              level;
  btn_state_e        state_q;
  logic [HOLD_W-1:0] cnt_hold_q;
  logic              press_pulse_q;
  logic              release_pulse_q;
  logic              short_press_q;
  logic              long_press_q;
  logic              long_hold_q;

  btn_sync_debounce #(
    .ACTIVE_LOW      (ACTIVE_LOW),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clk48   (clk48),
    .rst_n   (rst_n),
    .pad_i   (usr_btn),
    .level_o (level)
  );

  // Release is tested before the long threshold so a release landing on the
  // threshold cycle is reported as a short press.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      cnt_hold_q      <= '0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      short_press_q   <= 1'b0;
      long_press_q    <= 1'b0;
      long_hold_q     <= 1'b0;
    end else begin
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      short_press_q   <= 1'b0;
      long_press_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (level) begin
            state_q       <= ST_PRESSED;
            press_pulse_q <= 1'b1;
            cnt_hold_q    <= '0;
          end
        end
        ST_PRESSED: begin
          if (!level) begin
            state_q         <= ST_IDLE;
            release_pulse_q <= 1'b1;
            short_press_q   <= 1'b1;
          end else if (cnt_hold_q == HOLD_W'(LONG_CYCLES - 1)) begin
            state_q      <= ST_LONG;
            long_press_q <= 1'b1;
            long_hold_q  <= 1'b1;
          end else begin
            cnt_hold_q <= cnt_hold_q + HOLD_W'(1);
          end
        end
        ST_LONG: begin
          if (!level) begin
            state_q         <= ST_IDLE;
            release_pulse_q <= 1'b1;
            long_hold_q     <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          long_hold_q <= 1'b0;
        end
      endcase
    end
  end

  assign btn_level     = level;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign short_press   = short_press_q;
  assign long_press    = long_press_q;
  assign long_hold     = long_hold_q;

endmodule

// File: tb/tb_usr_btn_events.sv
// Bench for usr_btn_events: scoreboard of expected pulse cycles for directed
// presses, plus always-on protocol checks during random pad activity.
`timescale 1ns/1ps
module tb_usr_btn_events;

  localparam int unsigned DB       = 4;
  localparam int unsigned LONG_CYC = 20;
  localparam int unsigned LAT      = DB + 3;  // pad edge -> press/release pulse

  localparam logic [3:0] EV_PRESS = 4'b1000;
  localparam logic [3:0] EV_REL   = 4'b0100;
  localparam logic [3:0] EV_SHORT = 4'b0010;
  localparam logic [3:0] EV_LONG  = 4'b0001;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  vec;
  } sb_item_t;

  logic clk48 = 1'b0;
  logic rst_n;
  logic usr_btn;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic short_press;
  logic long_press;
  logic long_hold;

  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_press = 0;
  bit          sb_en = 1'b1;
  sb_item_t    sb_q[$];
  bit          open_press = 1'b0;
  int unsigned n_ends = 0;

  usr_btn_events #(
    .ACTIVE_LOW      (1'b1),
    .DEBOUNCE_CYCLES (DB),
    .LONG_CYCLES     (LONG_CYC)
  ) dut (
    .clk48         (clk48),
    .rst_n         (rst_n),
    .usr_btn       (usr_btn),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .short_press   (short_press),
    .long_press    (long_press),
    .long_hold     (long_hold)
  );

  always #5 clk48 = ~clk48;
  always @(posedge clk48) cyc <= cyc + 1;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic goto(input int unsigned n);
    while (cyc < n) @(negedge clk48);
  endtask

  function automatic void sb_push(input int unsigned c, input logic [3:0] v);
    sb_item_t it;
    it.cyc = c;
    it.vec = v;
    sb_q.push_back(it);
  endfunction

  // Pad pressed at t0 and released after `hold` cycles.
  function automatic void predict(input int unsigned t0, input int unsigned hold);
    sb_push(t0 + LAT, EV_PRESS);
    if (hold <= LONG_CYC) begin
      sb_push(t0 + hold + LAT, EV_REL | EV_SHORT);
    end else begin
      sb_push(t0 + LONG_CYC + LAT, EV_LONG);
      sb_push(t0 + hold + LAT, EV_REL);
    end
  endfunction

  // Scoreboard consumer and protocol checker.
  always @(negedge clk48) begin
    logic [3:0] pulses;
    sb_item_t   it;
    pulses = {press_pulse, release_pulse, short_press, long_press};
    if (!rst_n) begin
      open_press = 1'b0;
      n_ends     = 0;
    end else begin
      if (sb_en && (pulses != 4'b0 || (sb_q.size() != 0 && sb_q[0].cyc == cyc))) begin
        if (sb_q.size() == 0) begin
          check("unexpected_pulse", pulses, 0);
        end else begin
          it = sb_q.pop_front();
          check("pulse_cycle", cyc, it.cyc);
          check("pulse_vec", pulses, it.vec);
        end
      end
      if (pulses != 4'b0) begin
        check("exclusive", ($countones({press_pulse, release_pulse, long_press}) <= 1), 1);
        if (short_press) check("short_with_rel", release_pulse, 1);
        if (short_press || long_press) begin
          check("end_in_press", open_press, 1);
          n_ends++;
        end
        if (long_press) check("lh_on_long", long_hold, 1);
        if (press_pulse) begin
          check("alt_press", open_press, 0);
          open_press = 1'b1;
          n_ends     = 0;
          n_press++;
        end
        if (release_pulse) begin
          check("alt_release", open_press, 1);
          check("one_end", n_ends, 1);
          check("lh_off_rel", long_hold, 0);
          open_press = 1'b0;
        end
      end
    end
  end

  task automatic run_press(input int unsigned hold, input string tag);
    int unsigned t0;
    int unsigned th;
    t0 = cyc;
    th = t0 + hold;
    usr_btn = 1'b0;
    predict(t0, hold);
    goto(t0 + DB + 1); check({tag, "_lvl_pre"}, btn_level, 0);
    goto(t0 + DB + 2); check({tag, "_lvl_rise"}, btn_level, 1);
    if (hold >= LONG_CYC + LAT + 1) begin
      goto(t0 + LONG_CYC + LAT - 1); check({tag, "_lh_pre"}, long_hold, 0);
      goto(t0 + LONG_CYC + LAT);     check({tag, "_lh_set"}, long_hold, 1);
    end
    goto(th);
    usr_btn = 1'b1;
    goto(th + DB + 1); check({tag, "_lvl_hold"}, btn_level, 1);
    goto(th + DB + 2); check({tag, "_lvl_fall"}, btn_level, 0);
    check({tag, "_lh_before_rel"}, long_hold, (hold > LONG_CYC) ? 1 : 0);
    goto(th + LAT); check({tag, "_lh_after_rel"}, long_hold, 0);
    goto(th + 20); check({tag, "_sb_drain"}, sb_q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned t0;
    int unsigned tend;
    rst_n   = 1'b0;
    usr_btn = 1'b1;
    repeat (3) @(negedge clk48);
    check("rst_level", btn_level, 0);
    check("rst_press", press_pulse, 0);
    check("rst_release", release_pulse, 0);
    check("rst_short", short_press, 0);
    check("rst_long", long_press, 0);
    check("rst_hold", long_hold, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk48);

    run_press(30, "t1");

    // Low with a one-cycle high glitch every third cycle: never accepted.
    for (int i = 0; i < 40; i++) begin
      usr_btn = (i % 3 == 2);
      check("t2_level", btn_level, 0);
      @(negedge clk48);
    end
    usr_btn = 1'b1;
    repeat (10) begin
      check("t2_level_after", btn_level, 0);
      @(negedge clk48);
    end
    check("t2_sb_drain", sb_q.size(), 0);

    run_press(50, "t3");
    run_press(LONG_CYC, "t4");
    run_press(LONG_CYC + 1, "t4b");

    // Reset in the middle of a long hold, pad kept pressed throughout.
    t0 = cyc;
    usr_btn = 1'b0;
    sb_push(t0 + LAT, EV_PRESS);
    sb_push(t0 + LONG_CYC + LAT, EV_LONG);
    goto(t0 + LONG_CYC + LAT + 8);
    check("t5_lh_before", long_hold, 1);
    check("t5_sb_drain", sb_q.size(), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_level", btn_level, 0);
    check("t5_rst_hold", long_hold, 0);
    check("t5_rst_pulses", {press_pulse, release_pulse, short_press, long_press}, 0);
    repeat (2) @(negedge clk48);
    rst_n = 1'b1;
    run_press(40, "t5");

    // Random pad activity; only the protocol checker is active.
    sb_en = 1'b0;
    n_press = 0;
    tend = cyc + 10000;
    while (cyc < tend) begin
      usr_btn = ~usr_btn;
      repeat ($urandom_range(1, 40)) @(negedge clk48);
    end
    usr_btn = 1'b1;
    repeat (50) @(negedge clk48);
    check("t6_closed", open_press, 0);
    check("t6_activity", (n_press > 10), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
